qtree_lookup_buf: RTL and testbench

- Lookup front/back end wrapped around the quadtree pipeline. The tree pipeline cannot stall.
- Upstream side: accepts lookup requests on a valid/ready handshake and issues them as single-cycle lookup_en pulses into stage 0.
- Downstream side: captures every done/match/addr/data result from the match stage into a FIFO and presents it on a valid/ready interface.
- Credit accounting (in-flight plus stored) ensures no result is ever dropped.

---
 rtl/qtree_pkg.sv | 22 ++
 rtl/qtree_res_fifo.sv | 86 ++++++++
 rtl/qtree_lookup_buf.sv | 154 +++++++++++++++
 tb/tb_qtree_lookup_buf.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qtree_pkg.sv
// qtree_pkg: shared types and default widths for the quadtree lookup
// front/back end. The result record width is fixed here; the top-level
// D_WIDTH/A_WIDTH parameters default to these constants and must match them.
package qtree_pkg;

    localparam int QT_D_WIDTH = 16;
    localparam int QT_A_WIDTH = 14;
    localparam int QT_DEPTH   = 16;

    // One result word as returned by the match stage.
    typedef struct packed {
        logic                  match;
        logic [QT_A_WIDTH-1:0] addr;
        logic [QT_D_WIDTH-1:0] data;
    } qtree_res_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/qtree_res_fifo.sv
// qtree_res_fifo: synchronous FIFO of qtree_res_t with a registered head.
// The head register is loaded from the write data directly when the entry
// being written is the one that becomes head, so an empty FIFO shows a push
// one cycle later and a push+pop at count==1 has no bubble.
module qtree_res_fifo
    import qtree_pkg::*;
#(
    parameter int DEPTH     = QT_DEPTH,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  qtree_res_t           push_data_i,
    input  logic                 pop_i,
    output logic                 head_valid_o,
    output qtree_res_t           head_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    qtree_res_t           mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 head_valid_q, head_valid_d;
    qtree_res_t           head_q, head_d;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 full;

    assign full         = (count_q == CNT_WIDTH'(DEPTH));
    assign pop_ok       = pop_i && head_valid_q;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign push_ok      = push_i && (!full || pop_ok);

    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = !head_valid_q;

    // Next pointers, occupancy and the head word for the following cycle.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop_ok);
        count_d      = count_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
        head_valid_d = (count_d != '0);
        head_d       = head_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Storage array; contents are meaningless until written so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/qtree_lookup_buf.sv
// qtree_lookup_buf: request/issue front end and result FIFO back end around
// the non-stalling quadtree pipeline. Credits (in flight + stored) bound the
// number of outstanding lookups to the FIFO depth so no result is dropped.
// Optional: define QTREE_LOOKUP_STATS_EN to add saturating hit/miss counters.
module qtree_lookup_buf
    import qtree_pkg::*;
#(
    parameter int D_WIDTH   = QT_D_WIDTH,
    parameter int A_WIDTH   = QT_A_WIDTH,
    parameter int DEPTH     = QT_DEPTH,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic [D_WIDTH-1:0]   req_data_i,
    output logic                 req_ready_o,
    output logic                 lookup_en_o,
    output logic [D_WIDTH-1:0]   lookup_data_o,
    input  logic                 lookup_done_i,
    input  logic                 lookup_match_i,
    input  logic [A_WIDTH-1:0]   lookup_addr_i,
    input  logic [D_WIDTH-1:0]   lookup_data_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 res_match_o,
    output logic [A_WIDTH-1:0]   res_addr_o,
    output logic [D_WIDTH-1:0]   res_data_o,
    output logic [CNT_WIDTH-1:0] inflight_o,
    output logic                 err_o
`ifdef QTREE_LOOKUP_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    logic                 lookup_en_q, lookup_en_d;
    logic [D_WIDTH-1:0]   lookup_data_q, lookup_data_d;
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 err_q, err_d;

    logic [CNT_WIDTH:0]   occupancy;
    logic                 accept;
    logic                 done_ok;
    logic                 done_orphan;
    logic                 fifo_pop;
    logic                 fifo_drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_valid;
    logic [CNT_WIDTH-1:0] fifo_count;
    qtree_res_t           push_res;
    qtree_res_t           head_res;

    // Credit check uses registered state only, so ready never depends on valid.
    assign occupancy   = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign req_ready_o = rst_i && (occupancy < (CNT_WIDTH+1)'(DEPTH));
    assign accept      = req_valid_i && req_ready_o;

    // A result with nothing outstanding is spurious and is not stored.
    assign done_ok     = lookup_done_i && (inflight_q != '0);
    assign done_orphan = lookup_done_i && (inflight_q == '0);
    assign fifo_pop    = res_ready_i && !fifo_empty;
    assign fifo_drop   = done_ok && fifo_full && !fifo_pop;

    assign push_res.match = lookup_match_i;
    assign push_res.addr  = lookup_addr_i;
    assign push_res.data  = lookup_data_i;

    qtree_res_fifo #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_res_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (done_ok),
        .push_data_i  (push_res),
        .pop_i        (fifo_pop),
        .head_valid_o (head_valid),
        .head_o       (head_res),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign res_valid_o   = head_valid;
    assign res_match_o   = head_res.match;
    assign res_addr_o    = head_res.addr;
    assign res_data_o    = head_res.data;
    assign lookup_en_o   = lookup_en_q;
    assign lookup_data_o = lookup_data_q;
    assign inflight_o    = inflight_q;
    assign err_o         = err_q;

    // Issue pulse, in-flight accounting and sticky error next state.
    always_comb begin
        lookup_en_d   = accept;
        lookup_data_d = lookup_data_q;
        if (accept) begin
            lookup_data_d = req_data_i;
        end
        inflight_d = inflight_q + CNT_WIDTH'(accept) - CNT_WIDTH'(done_ok);
        err_d      = err_q || done_orphan || fifo_drop;
    end

    // Issue, credit and error registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lookup_en_q   <= 1'b0;
            lookup_data_q <= '0;
            inflight_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            lookup_en_q   <= lookup_en_d;
            lookup_data_q <= lookup_data_d;
            inflight_q    <= inflight_d;
            err_q         <= err_d;
        end
    end

`ifdef QTREE_LOOKUP_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Count every accepted result by its match flag, saturating.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (done_ok) begin
            if (lookup_match_i) begin
                hit_cnt_d = sat_inc32(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc32(miss_cnt_q);
            end
        end
    end

    // Hit/miss counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_qtree_lookup_buf.sv
// Bench for qtree_lookup_buf: a 6-cycle tree model answers every issue pulse,
// accepted requests push their expected result into a queue, and a monitor
// pops and compares each result the consumer takes.
module tb_qtree_lookup_buf;

    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int RW    = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          lookup_en;
    logic [DW-1:0] lookup_key;
    logic          done;
    logic          done_match;
    logic [AW-1:0] done_addr;
    logic [DW-1:0] done_data;
    logic          res_valid;
    logic          res_ready;
    logic          res_match;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_data;
    logic [CW-1:0] inflight;
    logic          err;
`ifdef QTREE_LOOKUP_STATS_EN
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [RW-1:0] exp_q [$];
    logic [DW:0]   pipe [7];
    logic          inj_done;
    logic [DW-1:0] inj_key;

    always #5 clk = ~clk;

    qtree_lookup_buf #(
        .D_WIDTH   (DW),
        .A_WIDTH   (AW),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .lookup_en_o    (lookup_en),
        .lookup_data_o  (lookup_key),
        .lookup_done_i  (done),
        .lookup_match_i (done_match),
        .lookup_addr_i  (done_addr),
        .lookup_data_i  (done_data),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_match_o    (res_match),
        .res_addr_o     (res_addr),
        .res_data_o     (res_data),
        .inflight_o     (inflight),
        .err_o          (err)
`ifdef QTREE_LOOKUP_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt)
`endif
    );

    // Tree answer for a key: match = key[0], addr = key[13:0] + 0x7E, data = ~key.
    function automatic logic [RW-1:0] model(input logic [DW-1:0] k);
        logic [AW-1:0] a;
        a = k[AW-1:0] + 14'h007E;
        return {k[0], a, ~k};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tree model: fixed 6-cycle latency from lookup_en to done, flushed by reset.
    always @(negedge clk) begin
        logic [RW-1:0] r;
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) pipe[i] = '0;
            done = 1'b0;
        end else begin
            for (int i = 6; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = {lookup_en, lookup_key};
            if (inj_done) begin
                r    = model(inj_key);
                done = 1'b1;
            end else begin
                r    = model(pipe[6][DW-1:0]);
                done = pipe[6][DW];
            end
            {done_match, done_addr, done_data} = r;
        end
    end

    // Scoreboard: pop/compare on each taken result, push on each accepted request.
    always @(negedge clk) begin
        logic [RW-1:0] e;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", {res_match, res_addr, res_data}, '0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {res_match, res_addr, res_data}, e);
            end
        end
        if (req_valid && req_ready) exp_q.push_back(model(req_data));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, cyc, nb, vc, first, last;

        // Reset held with a request pending.
        rst_n = 1'b0; req_valid = 1'b1; req_data = 16'h5555;
        res_ready = 1'b0; inj_done = 1'b0; inj_key = '0;
        done = 1'b0; done_match = 1'b0; done_addr = '0; done_data = '0;
        repeat (3) step();
        check("rst_ready", req_ready, 0);
        check("rst_lookup", {lookup_en, lookup_key}, 0);
        check("rst_res", {res_valid, res_match, res_addr, res_data}, 0);
        check("rst_inflight_err", {inflight, err}, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_ready", req_ready, 1);
        step();
        check("rel_ready_clk", req_ready, 1);

        // Single lookup, key 0x00A5.
        res_ready = 1'b1; req_valid = 1'b1; req_data = 16'h00A5;
        step();
        req_valid = 1'b0;
        check("t2_issue_en", lookup_en, 1);
        check("t2_issue_key", lookup_key, 16'h00A5);
        check("t2_inflight1", inflight, 1);
        step();
        check("t2_en_pulse", lookup_en, 0);
        cyc = 1;
        while (!res_valid && cyc < 20) begin step(); cyc++; end
        check("t2_latency", cyc, 7);
        check("t2_res", {res_match, res_addr, res_data}, {1'b1, 14'h0123, 16'hFF5A});
        check("t2_inflight0", inflight, 0);
        step();
        check("t2_valid_drop", res_valid, 0);

        // Back-pressure: 20 offered, only DEPTH accepted.
        res_ready = 1'b0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1; req_data = 16'h0100 + 16'(i);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        check("t3_accepted", acc, 16);
        check("t3_ready_low", req_ready, 0);
        repeat (10) step();
        check("t3_ready_still_low", req_ready, 0);
        check("t3_stored", {res_valid, inflight}, {1'b1, 5'd0});
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t3_ready_after_pop", req_ready, 1);
        res_ready = 1'b1; cyc = 0;
        while (res_valid && cyc < 40) begin step(); cyc++; end
        check("t3_drained", {res_valid, 32'(exp_q.size())}, 0);
        check("t3_drain_cycles", cyc, 15);

        // Streaming at full rate.
        nb = 0; vc = 0; first = -1; last = -1;
        for (int c = 0; c < 45; c++) begin
            req_valid = (c < 30); req_data = 16'h2000 + 16'(c);
            if (c < 30 && !req_ready) nb++;
            if (res_valid) begin
                vc++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        req_valid = 1'b0;
        check("t4_no_stall", nb, 0);
        check("t4_results", vc, 30);
        check("t4_first", first, 8);
        check("t4_no_bubble", last - first + 1, 30);
        check("t4_err", err, 0);
        check("t4_sb_empty", exp_q.size(), 0);

        // Orphan done with nothing in flight.
        check("t5_pre_inflight", inflight, 0);
        inj_key = 16'h0042; inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        check("t5_err_set", err, 1);
        check("t5_not_stored", {res_valid, inflight}, 0);
        repeat (5) step();
        check("t5_err_sticky", {err, res_valid}, {1'b1, 1'b0});

        // Asynchronous reset with 3 stored and 5 in flight.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_data = 16'h3000 + 16'(i);
            step();
        end
        req_valid = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_data = 16'h3100 + 16'(i);
            step();
        end
        req_valid = 1'b0;
        check("t6_pre_inflight", inflight, 5);
        check("t6_pre_valid", res_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", {inflight, res_valid, err, lookup_en}, 0);
        check("t6_ready_low", req_ready, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;

        // 3-hit / 2-miss sequence after reset.
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            case (i)
                0: req_data = 16'h0001;
                1: req_data = 16'h0003;
                2: req_data = 16'h0005;
                3: req_data = 16'h0002;
                default: req_data = 16'h0004;
            endcase
            step();
        end
        req_valid = 1'b0;
        repeat (12) step();
        check("t6_no_stale", {32'(exp_q.size()), res_valid, err}, 0);
`ifdef QTREE_LOOKUP_STATS_EN
        check("t6_hit_cnt", hit_cnt, 3);
        check("t6_miss_cnt", miss_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
